// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply/divide unit for MULT/MULTU/DIV/DIVU, holding the
// architectural HI/LO results between operations for MFHI/MFLO.
module mips_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [1:0]       state_o
);

   localparam int AW = 2 * WIDTH + 1;
   localparam int CW = $clog2(WIDTH);

   // Handshake: start_i is sampled on a rising edge only in IDLE or DONE;
   // busy_o covers RUN and SIGN, done_o is high for the single DONE cycle,
   // and a start held through DONE is accepted on the edge that leaves DONE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             neg_q, neg_d;
   logic             sign_a_q, sign_a_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dz_q, dz_d;

   logic             a_neg, b_neg, b_is_zero;
   logic [WIDTH-1:0] a_mag, b_mag;

   logic [WIDTH:0]   mul_upper;
   logic [AW-1:0]    mul_next;
   logic [AW-1:0]    div_shift;
   logic [WIDTH:0]   div_trial;
   logic [AW-1:0]    div_next;

   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quot_s, rem_s;

   // Operand magnitudes; only the signed ops look at the sign bits.
   always_comb begin
      a_neg     = op_i[0] & a_i[WIDTH-1];
      b_neg     = op_i[0] & b_i[WIDTH-1];
      a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
      b_mag     = b_neg ? (~b_i + 1'b1) : b_i;
      b_is_zero = (b_i == '0);
   end

   // Shift-add step: multiplier sits in the low half and drains out the right.
   always_comb begin
      mul_upper = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {1'b0, mul_upper, acc_q[WIDTH-1:1]};
   end

   // Restoring divide step on {remainder, quotient}.
   always_comb begin
      div_shift = {acc_q[AW-2:0], 1'b0};
      div_trial = div_shift[AW-1:WIDTH] - {1'b0, opnd_q};
      div_next  = div_trial[WIDTH] ? div_shift
                                   : {div_trial, div_shift[WIDTH-1:1], 1'b1};
   end

   // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
   always_comb begin
      prod_s = neg_q ? (~acc_q[2*WIDTH-1:0] + 1'b1) : acc_q[2*WIDTH-1:0];
      quot_s = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      rem_s  = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      sign_a_d = sign_a_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dz_d     = dz_q;

      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               if (op_i[1] && b_is_zero) begin
                  state_d = DONE;
                  hi_d    = a_i;
                  lo_d    = '1;
                  dz_d    = 1'b1;
               end else begin
                  state_d  = RUN;
                  op_d     = op_i;
                  neg_d    = a_neg ^ b_neg;
                  sign_a_d = a_neg;
                  cnt_d    = '0;
                  opnd_d   = op_i[1] ? b_mag : a_mag;
                  acc_d    = {{(WIDTH + 1){1'b0}}, (op_i[1] ? a_mag : b_mag)};
               end
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d = op_q[1] ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = SIGN;
            end
         end
         SIGN: begin
            if (op_q[1]) begin
               hi_d = rem_s;
               lo_d = quot_s;
            end else begin
               hi_d = prod_s[2*WIDTH-1:WIDTH];
               lo_d = prod_s[WIDTH-1:0];
            end
            dz_d    = 1'b0;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         sign_a_q <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         sign_a_q <= sign_a_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dz_q     <= dz_d;
      end
   end

   assign busy_o        = (state_q == RUN) || (state_q == SIGN);
   assign done_o        = (state_q == DONE);
   assign div_by_zero_o = dz_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
   assign state_o       = state_q;

endmodule
